obstacle_scheduler: RTL and testbench

- Decides when, where and what obstacle spawns next while the game runs.
- Sits between the game FSM and the obstacle datapath. Owns the pseudo-random source, the inter-obstacle gap timer, the difficulty/speed level and slot allocation for two obstacle slots.
- Hands each spawn to the obstacle datapath over a valid/ack handshake. Publishes the current speed level, which the obstacle and background movement logic use for scroll step.

---
 rtl/obstacle_scheduler_pkg.sv | 37 +++
 rtl/obstacle_scheduler_lfsr16.sv | 28 ++
 rtl/obstacle_scheduler.sv | 143 ++++++++++++++
 tb/tb_obstacle_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_scheduler_pkg.sv
// Shared encodings for the obstacle scheduler: game states, obstacle types,
// LFSR taps and the obstacle-type roll.
package obstacle_scheduler_pkg;

    localparam logic [1:0] GS_INIT = 2'b00;
    localparam logic [1:0] GS_RUN  = 2'b10;
    localparam logic [1:0] GS_DEAD = 2'b01;

    localparam logic [1:0] OBS_SMALL   = 2'b00;
    localparam logic [1:0] OBS_LARGE   = 2'b01;
    localparam logic [1:0] OBS_BIRD_LO = 2'b10;
    localparam logic [1:0] OBS_BIRD_HI = 2'b11;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          NUM_SLOTS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_PICK,
        S_WAIT_SLOT,
        S_OFFER,
        S_FROZEN
    } sched_state_t;

    // A roll of 11 degrades to a large cactus until birds are unlocked.
    function automatic logic [1:0] pick_type(input logic [2:0] rnd, input logic bird_ok);
        pick_type = OBS_SMALL;
        case (rnd[1:0])
            2'b10:   pick_type = OBS_LARGE;
            2'b11:   pick_type = bird_ok ? (rnd[2] ? OBS_BIRD_HI : OBS_BIRD_LO) : OBS_LARGE;
            default: pick_type = OBS_SMALL;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
module obstacle_scheduler_lfsr16
    import obstacle_scheduler_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/obstacle_scheduler.sv
// States: IDLE cleared | GAP frame countdown | PICK roll type+gap | WAIT_SLOT need free slot
//         OFFER spawn handshake | FROZEN game over, counters held
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int          MIN_GAP      = 24,
    parameter int          GAP_STEP     = 4,
    parameter int          LEVEL_FRAMES = 600,
    parameter int          MAX_LEVEL    = 7,
    parameter int          BIRD_LEVEL   = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic [1:0]           gameState,
    input  logic [NUM_SLOTS-1:0] slot_free,
    input  logic                 spawn_ack,
    output logic                 spawn_valid,
    output logic                 spawn_slot,
    output logic [1:0]           spawn_type,
    output logic [2:0]           speed_level
);

    localparam int                 LCNT_W       = $clog2(LEVEL_FRAMES);
    localparam logic [7:0]         L_MIN_GAP    = 8'(MIN_GAP);
    localparam logic [7:0]         L_GAP_STEP   = 8'(GAP_STEP);
    localparam logic [LCNT_W-1:0]  L_LCNT_LAST  = LCNT_W'(LEVEL_FRAMES - 1);
    localparam logic [2:0]         L_MAX_LEVEL  = 3'(MAX_LEVEL);
    localparam logic [2:0]         L_BIRD_LEVEL = 3'(BIRD_LEVEL);

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [7:0]        r_gap;
    logic [LCNT_W-1:0] r_lcnt;
    logic [2:0]        r_level;
    logic              r_slot;
    logic [1:0]        r_type;

    logic [15:0] w_lfsr;
    logic        w_unused;
    logic        w_run;
    logic        w_dead;
    logic        w_init;
    logic        w_active;
    logic        w_gap_done;
    logic        w_any_free;
    logic        w_free_slot;
    logic [7:0]  w_raw_rnd;
    logic [7:0]  w_level_sub;
    logic [7:0]  w_next_gap;

    obstacle_scheduler_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    assign w_unused    = ^w_lfsr[15:9];
    assign w_run       = (gameState == GS_RUN);
    assign w_dead      = (gameState == GS_DEAD);
    assign w_init      = (gameState == GS_INIT) || (gameState == 2'b11);
    assign w_active    = (r_state == S_GAP) || (r_state == S_PICK) ||
                         (r_state == S_WAIT_SLOT) || (r_state == S_OFFER);
    assign w_gap_done  = frame_tick && (r_gap <= 8'd1);
    assign w_any_free  = |slot_free;
    assign w_free_slot = ~slot_free[0];

    // Compare before subtracting so the level penalty can never wrap the gap.
    assign w_raw_rnd   = {2'b00, w_lfsr[8:3]};
    assign w_level_sub = {5'b00000, r_level} * L_GAP_STEP;
    assign w_next_gap  = (w_raw_rnd > w_level_sub) ? (L_MIN_GAP + w_raw_rnd - w_level_sub)
                                                   : L_MIN_GAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_dead) begin
            w_next = S_FROZEN;
        end else if (w_init) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_next = S_GAP;
                S_GAP:       if (w_gap_done) w_next = S_PICK;
                S_PICK:      w_next = S_WAIT_SLOT;
                S_WAIT_SLOT: if (w_any_free) w_next = S_OFFER;
                S_OFFER:     if (spawn_ack) w_next = S_GAP;
                S_FROZEN:    w_next = S_FROZEN;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        spawn_valid = (r_state == S_OFFER);
        spawn_slot  = r_slot;
        spawn_type  = r_type;
        speed_level = r_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap   <= L_MIN_GAP;
            r_lcnt  <= '0;
            r_level <= '0;
            r_slot  <= 1'b0;
            r_type  <= OBS_SMALL;
        end else if (w_init) begin
            r_gap   <= L_MIN_GAP;
            r_lcnt  <= '0;
            r_level <= '0;
        end else if (w_run) begin
            if (w_active && frame_tick) begin
                if (r_lcnt == L_LCNT_LAST) begin
                    r_lcnt <= '0;
                    if (r_level != L_MAX_LEVEL) r_level <= r_level + 1'b1;
                end else begin
                    r_lcnt <= r_lcnt + 1'b1;
                end
            end
            if ((r_state == S_GAP) && frame_tick && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 1'b1;
            end
            if (r_state == S_PICK) begin
                r_gap  <= w_next_gap;
                r_type <= pick_type(w_lfsr[2:0], r_level >= L_BIRD_LEVEL);
            end
            if ((r_state == S_WAIT_SLOT) && w_any_free) begin
                r_slot <= w_free_slot;
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: spawn timing, payload, slot choice,
// level progression, gap floor, freeze and reset behaviour.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       spawn_ack = 1'b0;
    logic [1:0] gameState = 2'b00;
    logic [1:0] slot_free = 2'b11;
    logic       spawn_valid;
    logic       spawn_slot;
    logic [1:0] spawn_type;
    logic [2:0] speed_level;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       slot;
        logic [1:0] typ;
    } spawn_t;

    spawn_t      sb_q[$];
    spawn_t      exp_s;
    logic [15:0] m_lfsr;
    logic [15:0] last_r;
    int          n_ticks = 0;
    bit          running = 1'b0;
    int          exp_gap = 24;
    int          lat;

    obstacle_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .gameState   (gameState),
        .slot_free   (slot_free),
        .spawn_ack   (spawn_ack),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_type  (spawn_type),
        .speed_level (speed_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR running in lock-step with the design.
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);

    function automatic int exp_level();
        return (n_ticks / 600 > 7) ? 7 : n_ticks / 600;
    endfunction

    function automatic logic [1:0] exp_type(input logic [15:0] r, input int lvl);
        if (r[1] == 1'b0) return 2'b00;
        if (r[0] == 1'b0 || lvl < 2) return 2'b01;
        return r[2] ? 2'b11 : 2'b10;
    endfunction

    function automatic int exp_next_gap(input logic [15:0] r, input int lvl);
        int v;
        int g;
        v = r[8:3];
        g = 24 + v - 4 * lvl;
        return (g < 24) ? 24 : g;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        if (running) n_ticks++;
        step(); step(); step();
    endtask

    task automatic accept();
        spawn_ack = 1'b1;
        step();
        spawn_ack = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (spawn_valid !== 1'b1 && cyc < budget) begin
            step();
            cyc++;
        end
        if (spawn_valid !== 1'b1) cyc = -1;
    endtask

    // Runs the gap down, choosing the expiring tick so that the rolled value
    // matches the requested pattern; ends in the PICK cycle with the
    // expected spawn pushed to the scoreboard.
    task automatic expire(input int mode, input logic slot);
        int          budget;
        bit          hit;
        logic [15:0] nx;
        spawn_t      e;
        for (int i = 0; i < exp_gap - 1; i++) tick();
        budget = 0;
        hit    = 1'b0;
        while (!hit && budget < 5000) begin
            nx = lfsr_next(m_lfsr);
            case (mode)
                1:       hit = (nx[1:0] == 2'b11);
                2:       hit = (nx[8:3] == 6'd0);
                3:       hit = (nx[8:3] == 6'd63);
                default: hit = 1'b1;
            endcase
            if (!hit) begin
                step();
                budget++;
            end
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL lfsr_search: pattern %0d not reached in %0d cycles", mode, budget);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n_ticks++;
        last_r = m_lfsr;
        e.slot = slot;
        e.typ  = exp_type(last_r, exp_level());
        sb_q.push_back(e);
        exp_gap = exp_next_gap(last_r, exp_level());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gameState = 2'b00;
        repeat (3) step();
        checks++; if (dut.w_lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr: got %h expected ace1", dut.w_lfsr); end
        rst = 1'b0;
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", spawn_valid); end
        checks++; if (spawn_slot !== 1'b0) begin errors++; $display("FAIL reset_slot: got %b expected 0", spawn_slot); end
        checks++; if (spawn_type !== 2'b00) begin errors++; $display("FAIL reset_type: got %b expected 00", spawn_type); end
        checks++; if (speed_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", speed_level); end
    endtask

    task automatic test_first_spawn();
        gameState = 2'b10;
        running   = 1'b1;
        n_ticks   = 0;
        exp_gap   = 24;
        slot_free = 2'b11;
        step();
        expire(0, 1'b0);
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL first_early: valid %b expected 0", spawn_valid); end
        step();
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL first_latency: valid %b expected 1", spawn_valid); end
        exp_s = sb_q.pop_front();
        checks++; if (spawn_slot !== exp_s.slot) begin errors++; $display("FAIL first_slot: got %b expected %b", spawn_slot, exp_s.slot); end
        checks++; if (spawn_type !== exp_s.typ) begin errors++; $display("FAIL first_type: got %b expected %b", spawn_type, exp_s.typ); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (spawn_valid !== 1'b1 || spawn_slot !== exp_s.slot || spawn_type !== exp_s.typ) begin
                errors++;
                $display("FAIL hold_stable: got v%b s%b t%b expected v1 s%b t%b",
                         spawn_valid, spawn_slot, spawn_type, exp_s.slot, exp_s.typ);
            end
        end
        accept();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL ack_drop: valid %b expected 0", spawn_valid); end
    endtask

    task automatic test_no_slot();
        slot_free = 2'b00;
        expire(0, 1'b1);
        spawn_ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL noslot_valid: got %b expected 0 (cycle %0d)", spawn_valid, i); end
        end
        spawn_ack = 1'b0;
        slot_free = 2'b10;
        wait_valid(2, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL slot1_wait: valid %b expected 1 within 2 cycles", spawn_valid); end
        exp_s = sb_q.pop_front();
        checks++; if (spawn_slot !== 1'b1) begin errors++; $display("FAIL slot1_index: got %b expected 1", spawn_slot); end
        checks++; if (spawn_type !== exp_s.typ) begin errors++; $display("FAIL slot1_type: got %b expected %b", spawn_type, exp_s.typ); end
        step();
        checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL slot1_hold: valid %b expected 1", spawn_valid); end
        accept();
        slot_free = 2'b11;
    endtask

    task automatic test_bird_gate();
        expire(0, 1'b0);
        wait_valid(4, lat);
        exp_s = sb_q.pop_front();
        checks++; if (lat < 0 || spawn_type !== exp_s.typ) begin errors++; $display("FAIL gate_pre_type: got %b expected %b (lat %0d)", spawn_type, exp_s.typ, lat); end
        while (n_ticks < 600) tick();
        checks++; if (speed_level !== 3'd1) begin errors++; $display("FAIL gate_level1: got %0d expected 1", speed_level); end
        accept();
        expire(1, 1'b0);
        wait_valid(4, lat);
        exp_s = sb_q.pop_front();
        checks++; if (lat < 0 || spawn_type !== 2'b01 || exp_s.typ !== 2'b01) begin errors++; $display("FAIL no_bird_lvl1: got %b expected 01 (lat %0d)", spawn_type, lat); end
        while (n_ticks < 1200) tick();
        checks++; if (speed_level !== 3'd2) begin errors++; $display("FAIL gate_level2: got %0d expected 2", speed_level); end
        accept();
        expire(1, 1'b0);
        wait_valid(4, lat);
        exp_s = sb_q.pop_front();
        checks++; if (lat < 0 || spawn_type !== exp_s.typ || spawn_type[1] !== 1'b1) begin errors++; $display("FAIL bird_lvl2: got %b expected %b (lat %0d)", spawn_type, exp_s.typ, lat); end
    endtask

    task automatic test_levels();
        while (n_ticks < 1800) tick();
        checks++; if (speed_level !== 3'd3) begin errors++; $display("FAIL level3: got %0d expected 3", speed_level); end
        while (n_ticks < 4199) tick();
        checks++; if (speed_level !== 3'd6) begin errors++; $display("FAIL level6_edge: got %0d expected 6", speed_level); end
        tick();
        checks++; if (speed_level !== 3'd7) begin errors++; $display("FAIL level7: got %0d expected 7", speed_level); end
        while (n_ticks < 5400) tick();
        checks++; if (speed_level !== 3'd7) begin errors++; $display("FAIL level_sat: got %0d expected 7", speed_level); end
        checks++; if (spawn_valid !== 1'b1 || spawn_type !== exp_s.typ) begin errors++; $display("FAIL offer_during_levels: got v%b t%b expected v1 t%b", spawn_valid, spawn_type, exp_s.typ); end
        accept();
    endtask

    task automatic test_gap_floor();
        int mode;
        for (int k = 0; k < 3; k++) begin
            mode = (k == 0) ? 2 : ((k == 1) ? 3 : 0);
            expire(mode, 1'b0);
            step();
            checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL gap_early_%0d: valid %b expected 0", k, spawn_valid); end
            step();
            checks++; if (spawn_valid !== 1'b1) begin errors++; $display("FAIL gap_latency_%0d: valid %b expected 1", k, spawn_valid); end
            exp_s = sb_q.pop_front();
            checks++; if (spawn_type !== exp_s.typ) begin errors++; $display("FAIL gap_type_%0d: got %b expected %b", k, spawn_type, exp_s.typ); end
            if (k < 2) accept();
        end
    endtask

    task automatic test_dead();
        gameState = 2'b01;
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL dead_valid: got %b expected 0", spawn_valid); end
        checks++; if (speed_level !== 3'd7) begin errors++; $display("FAIL dead_level: got %0d expected 7", speed_level); end
        running = 1'b0;
        repeat (5) tick();
        checks++; if (spawn_valid !== 1'b0 || speed_level !== 3'd7) begin errors++; $display("FAIL frozen_hold: got v%b l%0d expected v0 l7", spawn_valid, speed_level); end
        gameState = 2'b00;
        step();
        n_ticks = 0;
        checks++; if (speed_level !== 3'd0) begin errors++; $display("FAIL idle_level: got %0d expected 0", speed_level); end
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", spawn_valid); end
    endtask

    task automatic test_reset_mid();
        gameState = 2'b10;
        running   = 1'b1;
        n_ticks   = 0;
        exp_gap   = 24;
        slot_free = 2'b10;
        step();
        expire(0, 1'b1);
        wait_valid(4, lat);
        exp_s = sb_q.pop_front();
        checks++; if (lat < 0 || spawn_slot !== 1'b1) begin errors++; $display("FAIL mid_slot: got %b expected 1 (lat %0d)", spawn_slot, lat); end
        while (n_ticks < 600) tick();
        checks++; if (speed_level !== 3'd1) begin errors++; $display("FAIL mid_level: got %0d expected 1", speed_level); end
        spawn_ack = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if (spawn_valid !== 1'b0 || spawn_slot !== 1'b0 || spawn_type !== 2'b00 || speed_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v%b s%b t%b l%0d expected v0 s0 t00 l0",
                     spawn_valid, spawn_slot, spawn_type, speed_level);
        end
        checks++; if (dut.w_lfsr !== 16'hACE1) begin errors++; $display("FAIL mid_reset_lfsr: got %h expected ace1", dut.w_lfsr); end
        rst = 1'b0;
        spawn_ack = 1'b0;
        gameState = 2'b00;
        running = 1'b0;
        step();
        checks++; if (spawn_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", spawn_valid); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_spawn();
        test_no_slot();
        test_bird_gate();
        test_levels();
        test_gap_floor();
        test_dead();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
